dram_loader: RTL and testbench

Diagnostic writer for the 512×15 dispatch RAM (DRAM) read by the IR board. It assembles DRAM entries from 6-bit diagnostic load functions on the EBUS, generates the entry parity, and writes each entry into the DRAM port while the instruction path is not using it. After each write it reads the entry back and compares it. It also provides a bulk-fill mode for initialising the whole RAM. It sits between CTL's diagnostic decode and the DRAM memory's write port.

---
 rtl/dram_loader_pkg.sv | 43 ++++
 rtl/dram_loader_if.sv | 30 +++
 rtl/dram_entry_stage.sv | 43 ++++
 rtl/dram_loader.sv | 119 +++++++++++
 tb/tb_dram_loader.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_loader_pkg.sv
// Shared EBOX definitions for the dispatch RAM: diagnostic load function codes,
// entry packing, sizes and the entry parity rule.
package dram_loader_pkg;

  localparam int DRAM_SIZE  = 512;
  localparam int DRAM_WIDTH = 15;
  localparam int ADDR_W     = $clog2(DRAM_SIZE);

  typedef enum logic [2:0] {
    FN_ADDR_HI = 3'd0,
    FN_ADDR_LO = 3'd1,
    FN_AB      = 3'd2,
    FN_J1_4    = 3'd3,
    FN_COMMIT  = 3'd4,
    FN_FILL    = 3'd5,
    FN_CLEAR   = 3'd6,
    FN_NOP     = 3'd7
  } diag_func_e;

  // Most significant field first: A[0:2], B[0:2], P, J[1:4], J[7:10]
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic       p;
    logic [3:0] j1_4;
    logic [3:0] j7_10;
  } dram_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_READ,
    ST_CHECK
  } ld_state_e;

  // The IR checks odd parity over all 15 bits, so P completes an odd count.
  function automatic logic entry_parity(input logic [2:0] a, input logic [2:0] b,
                                        input logic [3:0] j1_4, input logic [3:0] j7_10);
    return ~^{a, b, j1_4, j7_10};
  endfunction

endpackage

// File: rtl/dram_loader_if.sv
// Diagnostic load and DRAM port signals between CTL, the loader and the DRAM.
// diag_data[5] carries EBUS data bit 0, diag_data[0] carries bit 5.
interface dram_loader_if;
  import dram_loader_pkg::*;

  logic                  diag_strobe;
  logic [2:0]            diag_func;
  logic [5:0]            diag_data;
  logic                  grant;
  logic [DRAM_WIDTH-1:0] dram_dout;
  logic [ADDR_W-1:0]     dram_addr;
  logic [DRAM_WIDTH-1:0] dram_din;
  logic                  dram_we;
  logic                  dram_req;
  logic                  busy;
  logic                  verify_err;
  logic                  overrun;
  logic [ADDR_W-1:0]     err_addr;

  modport master (
    output diag_strobe, diag_func, diag_data, grant, dram_dout,
    input  dram_addr, dram_din, dram_we, dram_req, busy, verify_err, overrun, err_addr
  );

  modport slave (
    input  diag_strobe, diag_func, diag_data, grant, dram_dout,
    output dram_addr, dram_din, dram_we, dram_req, busy, verify_err, overrun, err_addr
  );

endinterface

// File: rtl/dram_entry_stage.sv
// Staging register for one DRAM entry; presents the packed word with parity.
module dram_entry_stage
  import dram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load_ab,
  input  logic        i_load_j1_4,
  input  logic        i_load_j7_10,
  input  logic [5:0]  i_data,
  output dram_entry_t o_word
);

  logic [2:0] r_a;
  logic [2:0] r_b;
  logic [3:0] r_j1_4;
  logic [3:0] r_j7_10;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_j1_4  <= '0;
      r_j7_10 <= '0;
    end else begin
      if (i_load_ab) begin
        r_a <= i_data[5:3];
        r_b <= i_data[2:0];
      end
      if (i_load_j1_4)  r_j1_4  <= i_data[5:2];
      if (i_load_j7_10) r_j7_10 <= i_data[5:2];
    end
  end

  always_comb begin
    o_word.a     = r_a;
    o_word.b     = r_b;
    o_word.j1_4  = r_j1_4;
    o_word.j7_10 = r_j7_10;
    o_word.p     = entry_parity(r_a, r_b, r_j1_4, r_j7_10);
  end

endmodule

// File: rtl/dram_loader.sv
// Diagnostic DRAM writer: stages entries from EBUS load functions, writes them
// (singly or as a whole-RAM fill) when the port is granted, and verifies by readback.
module dram_loader
  import dram_loader_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  dram_loader_if.slave  bus
);

  // state    | meaning
  // ST_IDLE  | accepting load functions
  // ST_WAIT  | port requested, waiting for grant
  // ST_WRITE | write strobe to current address
  // ST_READ  | readback address presented
  // ST_CHECK | readback data compared against staged word

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_err_addr;
  logic              r_autoinc;
  logic              r_fill;
  logic              r_verify_err;
  logic              r_overrun;
  dram_entry_t       w_word;
  diag_func_e        w_fn;
  logic              w_accept;
  logic              w_mismatch;
  logic              w_last;
  logic              w_clear;

  assign w_fn       = diag_func_e'(bus.diag_func);
  assign w_accept   = bus.diag_strobe && (r_state == ST_IDLE);
  assign w_clear    = w_accept && (w_fn == FN_CLEAR);
  assign w_mismatch = (r_state == ST_CHECK) && (bus.dram_dout != w_word);
  assign w_last     = (r_addr == ADDR_W'(DRAM_SIZE - 1));

  dram_entry_stage u_stage (
    .clk          (clk),
    .reset        (reset),
    .i_load_ab    (w_accept && (w_fn == FN_AB)),
    .i_load_j1_4  (w_accept && (w_fn == FN_J1_4)),
    .i_load_j7_10 (w_accept && (w_fn == FN_COMMIT)),
    .i_data       (bus.diag_data),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && (w_fn == FN_COMMIT || w_fn == FN_FILL)) w_next = ST_WAIT;
      ST_WAIT:  if (bus.grant) w_next = ST_WRITE;
      ST_WRITE: w_next = ST_READ;
      ST_READ:  w_next = ST_CHECK;
      ST_CHECK: w_next = (r_fill && !w_last) ? ST_WAIT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.dram_we  = (r_state == ST_WRITE);
    bus.dram_req = (r_state != ST_IDLE);
    bus.busy     = (r_state != ST_IDLE);
    bus.dram_din = (r_state == ST_IDLE) ? '0 : w_word;
  end

  // Address counter: the +1 wraps 511 -> 0 for both autoinc and the end of a fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_autoinc <= 1'b0;
      r_fill    <= 1'b0;
    end else begin
      if (w_accept && w_fn == FN_ADDR_HI) begin
        r_addr[ADDR_W-1:3] <= bus.diag_data;
      end else if (w_accept && w_fn == FN_ADDR_LO) begin
        r_addr[2:0] <= bus.diag_data[5:3];
        r_autoinc   <= bus.diag_data[2];
      end else if (w_accept && w_fn == FN_FILL) begin
        r_addr <= '0;
      end else if (r_state == ST_CHECK && (r_fill || r_autoinc)) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_accept && w_fn == FN_FILL)                   r_fill <= 1'b1;
      else if (r_state == ST_CHECK && w_next == ST_IDLE) r_fill <= 1'b0;
    end
  end

  // A mismatch outranks a clear landing on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_verify_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_err_addr   <= '0;
    end else begin
      if (w_mismatch)   r_verify_err <= 1'b1;
      else if (w_clear) r_verify_err <= 1'b0;

      if (w_mismatch && !r_verify_err) r_err_addr <= r_addr;
      else if (w_clear)                r_err_addr <= '0;

      if (bus.diag_strobe && r_state != ST_IDLE) r_overrun <= 1'b1;
      else if (w_clear)                          r_overrun <= 1'b0;
    end
  end

  assign bus.dram_addr  = r_addr;
  assign bus.verify_err = r_verify_err;
  assign bus.overrun    = r_overrun;
  assign bus.err_addr   = r_err_addr;

endmodule

// File: tb/tb_dram_loader.sv
// Self-checking bench for dram_loader: table-driven single writes, randomized
// load functions against a behavioural model, and hand-written fill/reset sequences.
module tb_dram_loader;
  import dram_loader_pkg::*;

  typedef struct packed {
    logic [8:0]  a;
    logic [14:0] d;
  } wr_t;

  typedef struct {
    bit          load_addr;
    logic [5:0]  d_hi;
    logic [5:0]  d_lo;
    logic [5:0]  d_ab;
    logic [5:0]  d_j14;
    logic [5:0]  d_j710;
    int          gdelay;
    logic [8:0]  exp_waddr;
    logic [14:0] exp_wdata;
    logic [8:0]  exp_next;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dram_loader_if bus();
  dram_loader dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // DRAM model with one-cycle read latency; optional readback corruption
  logic [14:0] mem [DRAM_SIZE];
  logic        corrupt_on = 1'b0;
  wr_t         wq[$];

  always @(posedge clk) begin
    if (bus.dram_we) begin
      mem[bus.dram_addr] <= bus.dram_din;
      wq.push_back({bus.dram_addr, bus.dram_din});
    end
    bus.dram_dout <= mem[bus.dram_addr] ^
                     ((corrupt_on && (bus.dram_addr == 9'o040 || bus.dram_addr == 9'o100)) ? 15'h0001 : 15'h0000);
  end

  // Behavioural model: address, autoinc and staged fields as plain numbers
  int          m_addr;
  int          m_autoinc;
  int          m_a, m_b, m_j14, m_j710;
  wr_t         m_wr;

  function automatic logic [14:0] model_word();
    int   ones;
    logic p;
    ones = $countones({3'(m_a), 3'(m_b), 4'(m_j14), 4'(m_j710)});
    p = (ones % 2 == 0);
    return {3'(m_a), 3'(m_b), p, 4'(m_j14), 4'(m_j710)};
  endfunction

  task automatic model_reset();
    m_addr = 0; m_autoinc = 0; m_a = 0; m_b = 0; m_j14 = 0; m_j710 = 0;
  endtask

  task automatic model_fn(input int fn, input int d);
    case (fn)
      0: m_addr = d * 8 + m_addr % 8;
      1: begin m_addr = (m_addr / 8) * 8 + d / 8; m_autoinc = (d / 4) % 2; end
      2: begin m_a = d / 8; m_b = d % 8; end
      3: m_j14 = d / 4;
      4: begin
        m_j710 = d / 4;
        m_wr = {9'(m_addr), model_word()};
        if (m_autoinc != 0) m_addr = (m_addr + 1) % DRAM_SIZE;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int fn, input int d);
    bus.diag_strobe = 1'b1;
    bus.diag_func   = 3'(fn);
    bus.diag_data   = 6'(d);
    step();
    bus.diag_strobe = 1'b0;
    model_fn(fn, d);
  endtask

  // Commit with grant held low for gdelay cycles; optionally drop grant after WRITE
  task automatic commit(input int d, input int gdelay, input bit drop,
                        output int cyc, output bit req_ok);
    wq.delete();
    bus.grant = (gdelay == 0);
    op(4, d);
    cyc = 0;
    req_ok = 1'b1;
    for (int i = 0; i < gdelay; i++) begin
      if (!bus.dram_req || bus.dram_we) req_ok = 1'b0;
      cyc++;
      step();
    end
    bus.grant = 1'b1;
    while (bus.busy && cyc < 100) begin
      cyc++;
      step();
      if (drop) bus.grant = 1'b0;
    end
    bus.grant = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},    32'(bus.dram_addr), 32'd0);
    check({tag, "_din"},     32'(bus.dram_din), 32'd0);
    check({tag, "_we"},      32'(bus.dram_we), 32'd0);
    check({tag, "_req"},     32'(bus.dram_req), 32'd0);
    check({tag, "_busy"},    32'(bus.busy), 32'd0);
    check({tag, "_verr"},    32'(bus.verify_err), 32'd0);
    check({tag, "_overrun"}, 32'(bus.overrun), 32'd0);
    check({tag, "_erraddr"}, 32'(bus.err_addr), 32'd0);
  endtask

  vec_t vt[4];

  initial begin
    int          cyc;
    bit          req_ok;
    bit          order_ok;
    int          n;
    logic [14:0] fill_word;

    vt[0] = '{1, 6'o12, 6'o30, 6'o55, 6'o34, 6'o24, 0,  9'o123, 15'h5A75, 9'o123};
    vt[1] = '{1, 6'o12, 6'o30, 6'o55, 6'o34, 6'o24, 10, 9'o123, 15'h5A75, 9'o123};
    vt[2] = '{1, 6'o77, 6'o74, 6'o00, 6'o00, 6'o00, 0,  9'o777, 15'h0100, 9'o000};
    vt[3] = '{0, 6'o00, 6'o00, 6'o12, 6'o40, 6'o14, 2,  9'o000, 15'h1483, 9'o001};

    for (int i = 0; i < DRAM_SIZE; i++) mem[i] = 15'h0;
    bus.diag_strobe = 1'b0;
    bus.diag_func   = 3'd0;
    bus.diag_data   = 6'd0;
    bus.grant       = 1'b0;
    model_reset();

    #2 reset = 1'b1;
    step();
    step();
    check_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Table-driven single writes
    for (int i = 0; i < 4; i++) begin
      if (vt[i].load_addr) begin
        op(0, int'(vt[i].d_hi));
        op(1, int'(vt[i].d_lo));
      end
      op(2, int'(vt[i].d_ab));
      op(3, int'(vt[i].d_j14));
      commit(int'(vt[i].d_j710), vt[i].gdelay, 1'b0, cyc, req_ok);
      check($sformatf("vec%0d_nwrites", i), 32'(wq.size()), 32'd1);
      if (wq.size() > 0) begin
        check($sformatf("vec%0d_waddr", i), 32'(wq[0].a), 32'(vt[i].exp_waddr));
        check($sformatf("vec%0d_wdata", i), 32'(wq[0].d), 32'(vt[i].exp_wdata));
      end
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vt[i].gdelay + 4));
      if (vt[i].gdelay > 0) check($sformatf("vec%0d_req_hold", i), 32'(req_ok), 32'd1);
      check($sformatf("vec%0d_verr", i), 32'(bus.verify_err), 32'd0);
      check($sformatf("vec%0d_next_addr", i), 32'(bus.dram_addr), 32'(vt[i].exp_next));
    end

    // Randomized load functions against the model
    for (int it = 0; it < 60; it++) begin
      int fn;
      int d;
      fn = int'($urandom_range(0, 6));
      if (fn >= 5) fn = fn + 1;
      d = int'($urandom_range(0, 63));
      if (fn == 4) begin
        int  gd;
        bit  drop;
        gd   = int'($urandom_range(0, 4));
        drop = 1'($urandom_range(0, 1));
        commit(d, gd, drop, cyc, req_ok);
        check($sformatf("rnd%0d_nwrites", it), 32'(wq.size()), 32'd1);
        if (wq.size() > 0) check($sformatf("rnd%0d_write", it), 32'(wq[0]), 32'(m_wr));
        check($sformatf("rnd%0d_busy_cycles", it), 32'(cyc), 32'(gd + 4));
      end else begin
        op(fn, d);
        check($sformatf("rnd%0d_busy", it), 32'(bus.busy), 32'd0);
      end
      check($sformatf("rnd%0d_addr", it), 32'(bus.dram_addr), 32'(m_addr));
    end
    check("rnd_verr", 32'(bus.verify_err), 32'd0);
    check("rnd_overrun", 32'(bus.overrun), 32'd0);

    // Fill with corrupted readback at 0o40 and 0o100, strobe injected mid-fill
    op(0, 6'o17);
    op(2, 6'o36);
    op(3, 6'o24);
    fill_word = model_word();
    corrupt_on = 1'b1;
    wq.delete();
    bus.grant = 1'b1;
    op(5, 0);
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      cyc++;
      if (cyc == 100) begin
        bus.diag_strobe = 1'b1;
        bus.diag_func   = 3'd0;
        bus.diag_data   = 6'o77;
      end
      step();
      bus.diag_strobe = 1'b0;
    end
    bus.grant = 1'b0;
    corrupt_on = 1'b0;
    check("fill_cycles", 32'(cyc), 32'd2048);
    check("fill_nwrites", 32'(wq.size()), 32'd512);
    order_ok = (wq.size() == 512);
    n = -1;
    for (int i = 0; i < wq.size() && i < 512; i++) begin
      if (wq[i].a != 9'(i) || wq[i].d != fill_word) begin
        order_ok = 1'b0;
        if (n < 0) n = i;
      end
    end
    check("fill_order", 32'(order_ok), 32'd1);
    check("fill_addr_wrap", 32'(bus.dram_addr), 32'd0);
    check("fill_overrun", 32'(bus.overrun), 32'd1);
    check("fill_verr", 32'(bus.verify_err), 32'd1);
    check("fill_erraddr", 32'(bus.err_addr), 32'o40);
    op(6, 0);
    check("clear_verr", 32'(bus.verify_err), 32'd0);
    check("clear_overrun", 32'(bus.overrun), 32'd0);
    check("clear_erraddr", 32'(bus.err_addr), 32'd0);

    // Reset asserted while in WRITE
    wq.delete();
    bus.grant = 1'b1;
    op(4, 6'o10);
    n = 0;
    while (!bus.dram_we && n < 10) begin
      n++;
      step();
    end
    check("rst_reached_write", 32'(bus.dram_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    check("rst_hold_we", 32'(bus.dram_we), 32'd0);
    reset = 1'b0;
    bus.grant = 1'b0;
    model_reset();
    step();
    check("rst_no_write", 32'(wq.size()), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // A commit straight after reset writes the all-zero staged entry
    commit(0, 0, 1'b0, cyc, req_ok);
    check("post_rst_nwrites", 32'(wq.size()), 32'd1);
    if (wq.size() > 0) check("post_rst_write", 32'(wq[0]), 32'({9'd0, 15'h0100}));
    check("post_rst_verr", 32'(bus.verify_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
